// File: rtl/fft_pkg.sv
// fft_pkg: shared state type, bit reversal and twiddle constants
// for fft_stream (twiddles come from a 64-point Q16 cosine table).
package fft_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_UNLOAD
  } fft_state_e;

  localparam int MAX_LOG2 = 6;

  function automatic int bitrev(input int v, input int nb);
    int r;
    r = 0;
    for (int i = 0; i < nb; i++)
      r |= ((v >> i) & 1) << (nb - 1 - i);
    return r;
  endfunction

  // cos(2*pi*r/64) in Q16 for r = 0..16
  function automatic int qcos(input int r);
    case (r)
      0:  return 65536;
      1:  return 65220;
      2:  return 64277;
      3:  return 62714;
      4:  return 60547;
      5:  return 57798;
      6:  return 54491;
      7:  return 50660;
      8:  return 46341;
      9:  return 41576;
      10: return 36410;
      11: return 30893;
      12: return 25080;
      13: return 19024;
      14: return 12785;
      15: return 6424;
      default: return 0;
    endcase
  endfunction

  function automatic int cos64(input int k);
    int q;
    int r;
    q = (k >> 4) & 3;
    r = k & 15;
    case (q)
      0: return qcos(r);
      1: return -qcos(16 - r);
      2: return -qcos(r);
      default: return qcos(16 - r);
    endcase
  endfunction

  function automatic int sin64(input int k);
    return cos64((k - 16) & 63);
  endfunction

  function automatic int q16_to(input int v, input int frac);
    if (frac >= 16)
      return v <<< (frac - 16);
    return (v + (1 <<< (15 - frac))) >>> (16 - frac);
  endfunction

  function automatic int tw_re(
    input int m, input int n_log2, input int frac
  );
    return q16_to(cos64(m << (MAX_LOG2 - n_log2)), frac);
  endfunction

  function automatic int tw_im(
    input int m, input int n_log2, input int frac
  );
    return q16_to(-sin64(m << (MAX_LOG2 - n_log2)), frac);
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: combinational radix-2 DIT butterfly,
// x = a + round(b*w), y = a - round(b*w), w in Q2.(TW_W-2).
module fft_butterfly #(
  parameter int OW   = 16,
  parameter int TW_W = 10
) (
  input  logic signed [OW-1:0]   i_a_re,
  input  logic signed [OW-1:0]   i_a_im,
  input  logic signed [OW-1:0]   i_b_re,
  input  logic signed [OW-1:0]   i_b_im,
  input  logic signed [TW_W-1:0] i_w_re,
  input  logic signed [TW_W-1:0] i_w_im,
  output logic signed [OW-1:0]   o_x_re,
  output logic signed [OW-1:0]   o_x_im,
  output logic signed [OW-1:0]   o_y_re,
  output logic signed [OW-1:0]   o_y_im
);

  localparam int PW = OW + TW_W + 1;
  localparam int FR = TW_W - 2;
  localparam logic signed [PW-1:0] HALF =
    PW'(32'sd1 <<< (FR - 1));

  logic signed [PW-1:0] w_br;
  logic signed [PW-1:0] w_bi;
  logic signed [PW-1:0] w_wr;
  logic signed [PW-1:0] w_wi;
  logic signed [PW-1:0] w_pr;
  logic signed [PW-1:0] w_pi;
  logic signed [OW-1:0] w_p_re;
  logic signed [OW-1:0] w_p_im;

  assign w_br = PW'(i_b_re);
  assign w_bi = PW'(i_b_im);
  assign w_wr = PW'(i_w_re);
  assign w_wi = PW'(i_w_im);

  assign w_pr = w_br * w_wr - w_bi * w_wi;
  assign w_pi = w_br * w_wi + w_bi * w_wr;

  assign w_p_re = OW'((w_pr + HALF) >>> FR);
  assign w_p_im = OW'((w_pi + HALF) >>> FR);

  assign o_x_re = i_a_re + w_p_re;
  assign o_x_im = i_a_im + w_p_im;
  assign o_y_re = i_a_re - w_p_re;
  assign o_y_im = i_a_im - w_p_im;

endmodule

// File: rtl/fft_stream.sv
// fft_stream: streaming in-place radix-2 DIT FFT (load/compute/unload).
// Define FFT_MAG_EN to add the out_mag magnitude-estimate output.
module fft_stream
  import fft_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int N_LOG2 = 3,
  parameter int TW_W   = 10,
  localparam int OW    = DATA_W + N_LOG2 + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OW-1:0]     out_re,
  output logic signed [OW-1:0]     out_im,
  output logic [N_LOG2-1:0]        out_idx,
  output logic                     out_last,
  output logic                     busy
`ifdef FFT_MAG_EN
  ,
  output logic [OW-1:0]            out_mag
`endif
);

  localparam int N  = 1 << N_LOG2;
  localparam int NB = N / 2;
  localparam int BW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);
  localparam int FR = TW_W - 2;

  fft_state_e r_state;
  fft_state_e w_state_nx;

  logic [N_LOG2-1:0]    r_cnt;
  logic [SW-1:0]        r_stage;
  logic [BW-1:0]        r_bfly;
  logic signed [OW-1:0] r_re [N];
  logic signed [OW-1:0] r_im [N];

  logic signed [TW_W-1:0] w_tw_re [NB];
  logic signed [TW_W-1:0] w_tw_im [NB];

  logic w_in_fire;
  logic w_out_fire;
  logic w_last_bfly;
  logic w_last_stage;

  logic [N_LOG2-1:0]    w_wr_addr;
  logic signed [OW-1:0] w_in_ext;
  logic [N_LOG2-1:0]    w_b_ext;
  logic [N_LOG2-1:0]    w_mask;
  logic [N_LOG2-1:0]    w_off;
  logic [N_LOG2-1:0]    w_ia;
  logic [N_LOG2-1:0]    w_ib;
  logic [BW-1:0]        w_m;

  logic signed [OW-1:0] w_x_re;
  logic signed [OW-1:0] w_x_im;
  logic signed [OW-1:0] w_y_re;
  logic signed [OW-1:0] w_y_im;

  for (genvar g = 0; g < NB; g++) begin : g_tw
    localparam int TR = tw_re(g, N_LOG2, FR);
    localparam int TI = tw_im(g, N_LOG2, FR);
    assign w_tw_re[g] = TR[TW_W-1:0];
    assign w_tw_im[g] = TI[TW_W-1:0];
  end

  assign in_ready     = (r_state == ST_LOAD);
  assign out_valid    = (r_state == ST_UNLOAD);
  assign busy         = (r_state == ST_COMPUTE) ||
                        (r_state == ST_UNLOAD);
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;
  assign w_last_bfly  = (r_bfly == BW'(NB - 1));
  assign w_last_stage = (r_stage == SW'(N_LOG2 - 1));

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_LOAD:
        if (w_in_fire && r_cnt == N_LOG2'(N - 1))
          w_state_nx = ST_COMPUTE;
      ST_COMPUTE:
        if (w_last_bfly && w_last_stage)
          w_state_nx = ST_UNLOAD;
      ST_UNLOAD:
        if (w_out_fire && r_cnt == N_LOG2'(N - 1))
          w_state_nx = ST_LOAD;
      default:
        w_state_nx = ST_LOAD;
    endcase
  end

  // r_cnt is the load count, then the unload bin; it wraps at N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
      r_stage <= '0;
      r_bfly  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_in_fire || w_out_fire)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_COMPUTE) begin
        r_bfly <= r_bfly + 1'b1;
        if (w_last_bfly)
          r_stage <= w_last_stage ? '0 : r_stage + 1'b1;
      end
    end
  end

  assign w_wr_addr = N_LOG2'(bitrev(int'(r_cnt), N_LOG2));
  assign w_in_ext  = {{(OW - DATA_W){in_data[DATA_W-1]}}, in_data};

  // a = group*2^(s+1) + off, partner a + 2^s, exponent off*N/2^(s+1)
  always_comb begin
    w_b_ext = {1'b0, r_bfly};
    w_mask  = N_LOG2'((32'd1 << r_stage) - 32'd1);
    w_off   = w_b_ext & w_mask;
    w_ia    = ((w_b_ext & ~w_mask) << 1) | w_off;
    w_ib    = w_ia | N_LOG2'(32'd1 << r_stage);
    w_m     = BW'(w_off << (BW - int'(r_stage)));
  end

  fft_butterfly #(
    .OW  (OW),
    .TW_W(TW_W)
  ) u_bfly (
    .i_a_re(r_re[w_ia]),
    .i_a_im(r_im[w_ia]),
    .i_b_re(r_re[w_ib]),
    .i_b_im(r_im[w_ib]),
    .i_w_re(w_tw_re[w_m]),
    .i_w_im(w_tw_im[w_m]),
    .o_x_re(w_x_re),
    .o_x_im(w_x_im),
    .o_y_re(w_y_re),
    .o_y_im(w_y_im)
  );

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_re[w_wr_addr] <= w_in_ext;
      r_im[w_wr_addr] <= '0;
    end else if (r_state == ST_COMPUTE) begin
      r_re[w_ia] <= w_x_re;
      r_im[w_ia] <= w_x_im;
      r_re[w_ib] <= w_y_re;
      r_im[w_ib] <= w_y_im;
    end
  end

  assign out_re   = out_valid ? r_re[r_cnt] : '0;
  assign out_im   = out_valid ? r_im[r_cnt] : '0;
  assign out_idx  = out_valid ? r_cnt : '0;
  assign out_last = out_valid && (r_cnt == N_LOG2'(N - 1));

`ifdef FFT_MAG_EN
  logic [OW-1:0] w_abs_re;
  logic [OW-1:0] w_abs_im;
  logic [OW-1:0] w_max;
  logic [OW-1:0] w_min;

  always_comb begin
    w_abs_re = out_re[OW-1] ? (~out_re + 1'b1) : out_re;
    w_abs_im = out_im[OW-1] ? (~out_im + 1'b1) : out_im;
    w_max    = (w_abs_re > w_abs_im) ? w_abs_re : w_abs_im;
    w_min    = (w_abs_re > w_abs_im) ? w_abs_im : w_abs_re;
  end

  assign out_mag = w_max + (w_min >> 1);
`endif

endmodule

// File: doc/fft_stream.md
FFT_STREAM -- requirements
Module: fft_stream

Interface
REQ-001 The parameter DATA_W SHALL default to 12 and SHALL set the input sample width (signed, 4..16).
REQ-002 The parameter N_LOG2 SHALL default to 3 and SHALL set the transform length N=2^N_LOG2 (range 2..6).
REQ-003 The parameter TW_W SHALL default to 10 and SHALL set the signed twiddle width, format Q2.(TW_W-2), so that ±1 is exact.
REQ-004 The port clk SHALL be an input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The port rst_n SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-006 in_valid input 1, in_ready output 1, in_data input DATA_W signed: real sample stream.
REQ-007 out_valid output 1, out_ready input 1: the result handshake.
REQ-008 out_re and out_im SHALL be outputs, OW=DATA_W+N_LOG2+1 bits, signed: the bin value.
REQ-009 out_idx SHALL be an output, N_LOG2 bits: the bin index. out_last SHALL be an output, 1 bit: set on bin N-1.
REQ-010 busy SHALL be an output, 1 bit: high in COMPUTE and UNLOAD.

Function
REQ-011 The FSM SHALL have the states LOAD, COMPUTE and UNLOAD, with transitions LOAD->COMPUTE->UNLOAD->LOAD only.
REQ-012 In LOAD, in_ready SHALL be 1; each in_valid&&in_ready SHALL write the sign-extended sample to buffer address bitrev(count), with the imaginary part set to 0.
REQ-013 The Nth accepted sample SHALL move the FSM to COMPUTE on the next edge, and in_ready SHALL be 0 from that edge onward.
REQ-014 COMPUTE SHALL run an in-place radix-2 DIT FFT, X[k]=sum x[n]·e^(-j2πnk/N), at one butterfly per cycle, for exactly N_LOG2·N/2 cycles.
REQ-015 Stage s, butterfly b SHALL use partners a and a+2^s with twiddle W_N^((b mod 2^s)·N/2^(s+1)).
REQ-016 Butterfly arithmetic SHALL compute p=B·W with full-precision products, then apply round-half-up and an arithmetic shift right by TW_W-2, then form A+p and A-p at OW bits with no per-stage scaling and no saturation.
REQ-017 In UNLOAD, out_valid SHALL be 1 and SHALL present bin out_idx in natural order 0..N-1; the bin SHALL advance only on out_valid&&out_ready.
REQ-018 While out_ready=0, out_re, out_im, out_idx and out_last SHALL hold stable.
REQ-019 Acceptance of bin N-1 SHALL return the FSM to LOAD, with in_ready=1 on the next cycle.
REQ-020 in_valid outside LOAD SHALL be ignored, and no sample SHALL be dropped or counted.
REQ-021 Total latency from the last accepted input to the first out_valid SHALL be N_LOG2·N/2+1 cycles.

Reset
REQ-022 On rst_n=0, regardless of the current state, the block SHALL immediately set the FSM to LOAD; all counters to 0; in_ready=1, out_valid=0, busy=0, out_re=0, out_im=0, out_idx=0 and out_last=0.
REQ-023 The buffer contents SHALL NOT require reset, and a frame interrupted by reset SHALL be discarded entirely.

Configuration
REQ-024 When FFT_MAG_EN is defined, the block SHALL add the output out_mag (OW bits, unsigned) equal to max(|re|,|im|)+(min(|re|,|im|)>>1), valid with out_valid and held under backpressure.
REQ-025 When FFT_MAG_EN is undefined, out_mag and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 The shared package fft_pkg SHALL hold the state enum, the bitrev function, and the twiddle-table function generating Q2.(TW_W-2) cos/−sin constants for N up to 64 at elaboration.
REQ-027 The sub-module fft_butterfly SHALL be purely combinational, with inputs A, B and W and outputs A+BW and A−BW, and SHALL be instantiated once.
REQ-028 The buffer SHALL be a register array of N complex OW-bit entries.

Verification (DATA_W=12, N_LOG2=3, TW_W=10)
REQ-029 Impulse input 1,0,0,0,0,0,0,0 -> all 8 bins SHALL be re=1, im=0, with out_last on idx 7.
REQ-030 Constant input 100 ×8 -> bin0 SHALL be 800+0j, and bins 1..7 SHALL be 0+0j.
REQ-031 Input 10,5,-10,12,-15,14,0,-9 -> bin0 SHALL be 7+0j, bin2 SHALL be 5-16j, bin4 SHALL be -37+0j, and bin6 SHALL be 5+16j.
REQ-032 Alternating input 100,-100 ×4 with out_ready toggled every other cycle -> bin4 SHALL be 800+0j, outputs SHALL hold while out_ready=0, and exactly 8 transfers SHALL occur.
REQ-033 Asserting rst_n low during COMPUTE, then loading the impulse frame -> outputs SHALL match REQ-029, with no residue from the aborted frame.
REQ-034 With FFT_MAG_EN defined and input 100 ×8 -> out_mag SHALL be 800 on bin0 and 0 on all other bins.
